// File: rtl/modport_axi_pkg.sv
// Shared types and address/response helpers for the modport_axi_slave block.
package modport_axi_pkg;

  typedef enum logic [1:0] {
    FIXED    = 2'b00,
    INCR     = 2'b01,
    WRAP     = 2'b10,
    RESERVED = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Address of the beat after addr; WRAP folds inside a (len+1)*2^size window.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [3:0]  len,
                                            input logic [1:0]  burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst_e'(burst))
      INCR:    next_addr = addr + step;
      WRAP:    next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: next_addr = addr;
    endcase
  endfunction

  // Bursts that are answered with SLVERR and never touch memory.
  function automatic logic illegal_xfer(input logic [1:0] burst,
                                        input logic [2:0] size);
    return (burst_e'(burst) == RESERVED) || (size > 3'd2);
  endfunction

  function automatic logic wrap_len_bad(input logic [1:0] burst,
                                        input logic [3:0] len);
    return (burst_e'(burst) == WRAP) &&
           !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
  endfunction

  function automatic logic [1:0] resp_code(input logic dec, input logic slv);
    resp_e r;
    r = dec ? DECERR : (slv ? SLVERR : OKAY);
    return r;
  endfunction

endpackage

// File: rtl/modport_axi_mem.sv
// Byte-enabled word RAM: one synchronous write port, one combinational read port.
module modport_axi_mem #(
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         i_wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] i_wr_idx,
  input  logic [31:0]                  i_wr_data,
  input  logic [3:0]                   i_wr_strb,
  input  logic [$clog2(MEM_WORDS)-1:0] i_rd_idx,
  output logic [31:0]                  o_rd_data
);

  logic [31:0] r_mem [MEM_WORDS];

  // NOTE: the array has no reset; its contents must survive rst, and a reset
  // on a memory prevents RAM inference.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_strb[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  // The reader registers this at the same edge as a write, so it sees old data.
  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/modport_axi_slave.sv
// AXI3-style memory slave: one write burst and one read burst in flight, independently.
// Define MODPORT_AXI_SLAVE_WID_CHECK_EN to report wid/awid mismatches as SLVERR.
module modport_axi_slave #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);
  import modport_axi_pkg::*;

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;

  // ---------------- write engine ----------------
  wr_state_e   r_wr_state, w_wr_state_nx;
  logic        r_awready, r_wready, r_bvalid;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_wr_id, r_wr_len, r_wr_beat;
  logic [31:0] r_wr_addr;
  logic [2:0]  r_wr_size;
  logic [1:0]  r_wr_burst;
  logic        r_wr_nocommit, r_wr_slverr, r_wr_decerr;

  logic w_aw_hs, w_w_hs, w_b_hs, w_wr_last_beat, w_wr_beat_dec, w_wr_beat_slv, w_wr_en;

  assign w_aw_hs        = r_awready && awvalid;
  assign w_w_hs         = r_wready && wvalid;
  assign w_b_hs         = r_bvalid && bready;
  assign w_wr_last_beat = (r_wr_beat == r_wr_len);
  assign w_wr_beat_dec  = (r_wr_addr >= MEM_BYTES);
`ifdef MODPORT_AXI_SLAVE_WID_CHECK_EN
  assign w_wr_beat_slv  = (wlast != w_wr_last_beat) || (wid != r_wr_id);
`else
  logic w_unused_wid;
  assign w_unused_wid   = ^wid;
  assign w_wr_beat_slv  = (wlast != w_wr_last_beat);
`endif
  assign w_wr_en        = w_w_hs && !r_wr_nocommit && !w_wr_beat_dec;

  // NOTE: every always_comb output gets its default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_wr_state_nx = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (w_aw_hs) w_wr_state_nx = W_DATA;
      W_DATA:  if (w_w_hs && w_wr_last_beat) w_wr_state_nx = W_RESP;
      W_RESP:  if (w_b_hs) w_wr_state_nx = W_IDLE;
      default: w_wr_state_nx = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wr_state <= W_IDLE;
    else     r_wr_state <= w_wr_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awready     <= 1'b0;
      r_wready      <= 1'b0;
      r_bvalid      <= 1'b0;
      r_bid         <= '0;
      r_bresp       <= '0;
      r_wr_id       <= '0;
      r_wr_addr     <= '0;
      r_wr_len      <= '0;
      r_wr_size     <= '0;
      r_wr_burst    <= '0;
      r_wr_beat     <= '0;
      r_wr_nocommit <= 1'b0;
      r_wr_slverr   <= 1'b0;
      r_wr_decerr   <= 1'b0;
    end else begin
      // Handshake outputs are decoded from the next state so they are registered.
      r_awready <= (w_wr_state_nx == W_IDLE);
      r_wready  <= (w_wr_state_nx == W_DATA);
      r_bvalid  <= (w_wr_state_nx == W_RESP);
      if (w_aw_hs) begin
        r_wr_id       <= awid;
        r_wr_addr     <= awaddr;
        r_wr_len      <= awlen;
        r_wr_size     <= awsize;
        r_wr_burst    <= awburst;
        r_wr_beat     <= '0;
        r_wr_nocommit <= illegal_xfer(awburst, awsize);
        r_wr_slverr   <= illegal_xfer(awburst, awsize) || wrap_len_bad(awburst, awlen);
        r_wr_decerr   <= 1'b0;
      end
      if (w_w_hs) begin
        r_wr_addr   <= next_addr(r_wr_addr, r_wr_size, r_wr_len, r_wr_burst);
        r_wr_beat   <= r_wr_beat + 4'd1;
        r_wr_slverr <= r_wr_slverr || w_wr_beat_slv;
        r_wr_decerr <= r_wr_decerr || w_wr_beat_dec;
        if (w_wr_last_beat) begin
          r_bid   <= r_wr_id;
          r_bresp <= resp_code(r_wr_decerr || w_wr_beat_dec, r_wr_slverr || w_wr_beat_slv);
        end
      end
    end
  end

  // ---------------- read engine ----------------
  rd_state_e   r_rd_state, w_rd_state_nx;
  logic        r_arready, r_rvalid, r_rlast;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] r_rd_addr;
  logic [3:0]  r_rd_len, r_rd_beat;
  logic [2:0]  r_rd_size;
  logic [1:0]  r_rd_burst;
  logic        r_rd_slverr;

  logic        w_ar_hs, w_r_hs, w_rd_dec, w_rd_slv;
  logic [31:0] w_rd_addr_nx, w_rd_beat_addr, w_mem_rdata;

  assign w_ar_hs        = r_arready && arvalid;
  assign w_r_hs         = r_rvalid && rready;
  assign w_rd_addr_nx   = next_addr(r_rd_addr, r_rd_size, r_rd_len, r_rd_burst);
  // Address of the beat being loaded: the request itself in idle, else the next beat.
  assign w_rd_beat_addr = (r_rd_state == R_IDLE) ? araddr : w_rd_addr_nx;
  assign w_rd_dec       = (w_rd_beat_addr >= MEM_BYTES);
  assign w_rd_slv       = (r_rd_state == R_IDLE)
                          ? (illegal_xfer(arburst, arsize) || wrap_len_bad(arburst, arlen))
                          : r_rd_slverr;

  always_comb begin
    w_rd_state_nx = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs) w_rd_state_nx = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rd_state_nx = R_IDLE;
      default: w_rd_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_state <= R_IDLE;
    else     r_rd_state <= w_rd_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_rid       <= '0;
      r_rdata     <= '0;
      r_rresp     <= '0;
      r_rd_addr   <= '0;
      r_rd_len    <= '0;
      r_rd_beat   <= '0;
      r_rd_size   <= '0;
      r_rd_burst  <= '0;
      r_rd_slverr <= 1'b0;
    end else begin
      r_arready <= (w_rd_state_nx == R_IDLE);
      r_rvalid  <= (w_rd_state_nx == R_DATA);
      if (w_ar_hs) begin
        r_rid       <= arid;
        r_rd_addr   <= araddr;
        r_rd_len    <= arlen;
        r_rd_size   <= arsize;
        r_rd_burst  <= arburst;
        r_rd_beat   <= '0;
        r_rd_slverr <= w_rd_slv;
        r_rdata     <= w_rd_dec ? 32'd0 : w_mem_rdata;
        r_rresp     <= resp_code(w_rd_dec, w_rd_slv);
        r_rlast     <= (arlen == 4'd0);
      end else if (w_r_hs && !r_rlast) begin
        r_rd_addr <= w_rd_addr_nx;
        r_rd_beat <= r_rd_beat + 4'd1;
        r_rdata   <= w_rd_dec ? 32'd0 : w_mem_rdata;
        r_rresp   <= resp_code(w_rd_dec, w_rd_slv);
        r_rlast   <= ((r_rd_beat + 4'd1) == r_rd_len);
      end
    end
  end

  modport_axi_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_wr_addr[AW+1:2]),
    .i_wr_data (wdata),
    .i_wr_strb (wstrb),
    .i_rd_idx  (w_rd_beat_addr[AW+1:2]),
    .o_rd_data (w_mem_rdata)
  );

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bid     = r_bid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rlast   = r_rlast;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule

// File: tb/tb_modport_axi_slave.sv
// Self-checking bench for modport_axi_slave: directed scenarios plus randomized
// bursts against a byte-level reference memory.
module tb_modport_axi_slave;

  localparam int MEM_WORDS = 256;
  localparam int MEM_BYTES = MEM_WORDS * 4;
  localparam int TIMEOUT   = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0, wid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]  awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  modport_axi_slave #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          rd_unstable, rd_cycles, rd_rid_bad;
  logic        rd_end_valid;
  logic [31:0] exp_data [16];
  logic [1:0]  exp_resp [16];

  // ---------------- reference model ----------------
  function automatic int beat_addr(input int start, input int size, input int len,
                                   input int burst, input int i);
    int step, total, base;
    step  = 1 << size;
    total = (len + 1) * step;
    case (burst)
      1: return start + i * step;
      2: begin
        base = (start / total) * total;
        return base + ((start - base + i * step) % total);
      end
      default: return start;
    endcase
  endfunction

  function automatic bit burst_slverr(input int len, input int size, input int burst);
    return (burst == 3) || (size > 2) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic model_write(input int addr, input int len, input int size, input int burst,
                             output logic [1:0] exp);
    int a;
    bit dec;
    dec = 0;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, size, len, burst, i);
      if (a >= MEM_BYTES) dec = 1;
      else if (!(burst == 3 || size > 2))
        for (int b = 0; b < 4; b++)
          if (wr_strb[i][b]) model_mem[a / 4][8*b +: 8] = wr_data[i][8*b +: 8];
    end
    exp = dec ? 2'b11 : (burst_slverr(len, size, burst) ? 2'b10 : 2'b00);
  endtask

  task automatic model_read(input int addr, input int len, input int size, input int burst);
    int a;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, size, len, burst, i);
      exp_data[i] = (a >= MEM_BYTES) ? 32'd0 : model_mem[a / 4];
      exp_resp[i] = (a >= MEM_BYTES) ? 2'b11 : (burst_slverr(len, size, burst) ? 2'b10 : 2'b00);
    end
  endtask

  task automatic timeout_fail(input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout after %0d cycles, handshake required", what, TIMEOUT);
  endtask

  // ---------------- bus drivers (called just after a falling edge) ----------------
  task automatic do_write(input int id, input int addr, input int len, input int size,
                          input int burst, input int early_last, input int wid_v,
                          output logic [1:0] got_resp, output logic [3:0] got_bid,
                          output bit ok);
    int t;
    ok = 1;
    got_resp = 'x;
    got_bid = 'x;
    awid = 4'(id); awaddr = 32'(addr); awlen = 4'(len); awsize = 3'(size);
    awburst = 2'(burst); awvalid = 1'b1;
    t = 0;
    while (!awready && t < TIMEOUT) begin @(negedge clk); t++; end
    if (t >= TIMEOUT) begin ok = 0; timeout_fail("aw_handshake"); end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len && ok; i++) begin
      wid = 4'(wid_v); wdata = wr_data[i]; wstrb = wr_strb[i];
      wlast = (early_last >= 0) ? (i == early_last) : (i == len);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < TIMEOUT) begin @(negedge clk); t++; end
      if (t >= TIMEOUT) begin ok = 0; timeout_fail("w_beat"); end
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bready = 1'b1;
    t = 0;
    while (ok && !bvalid && t < TIMEOUT) begin @(negedge clk); t++; end
    if (ok && t >= TIMEOUT) begin ok = 0; timeout_fail("b_handshake"); end
    got_resp = bresp;
    got_bid = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input int id, input int addr, input int len, input int size,
                         input int burst, input bit toggle, output bit ok);
    int t, n;
    bit have_hold;
    logic [34:0] hold;
    ok = 1;
    arid = 4'(id); araddr = 32'(addr); arlen = 4'(len); arsize = 3'(size);
    arburst = 2'(burst); arvalid = 1'b1;
    t = 0;
    while (!arready && t < TIMEOUT) begin @(negedge clk); t++; end
    if (t >= TIMEOUT) begin ok = 0; timeout_fail("ar_handshake"); end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0; t = 0; rd_unstable = 0; rd_cycles = 0; rd_rid_bad = 0; have_hold = 0;
    hold = '0;
    while (ok && n <= len && t < TIMEOUT) begin
      rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid) begin
        rd_cycles++;
        if (have_hold && ({rdata, rresp, rlast} !== hold)) rd_unstable++;
        if (rready) begin
          rd_data[n] = rdata; rd_resp[n] = rresp; rd_last[n] = rlast;
          if (rid !== 4'(id)) rd_rid_bad++;
          n++;
          have_hold = 0;
        end else begin
          hold = {rdata, rresp, rlast};
          have_hold = 1;
        end
      end
      @(negedge clk);
      t++;
    end
    rready = 1'b0;
    rd_end_valid = rvalid;
    if (ok && n <= len) begin ok = 0; timeout_fail("r_beats"); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b rdata=%h, all 0 required",
               awready, wready, bvalid, arready, rvalid, rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({awready, arready} !== 2'b11) begin
      miscompares++;
      $display("FAIL ready_after_reset: got awready=%b arready=%b, 1/1 required", awready, arready);
    end
  endtask

  task automatic test_fill();
    logic [1:0] r, e;
    logic [3:0] b;
    bit ok;
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      do_write(blk, blk * 64, 15, 2, 1, -1, blk, r, b, ok);
      model_write(blk * 64, 15, 2, 1, e);
      vectors++;
      if (r !== e) begin
        miscompares++;
        $display("FAIL fill_bresp: block %0d got %b required %b", blk, r, e);
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] r, e;
    logic [3:0] b;
    bit ok;
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    do_write(5, 32'h10, 0, 2, 1, -1, 5, r, b, ok);
    model_write(32'h10, 0, 2, 1, e);
    vectors++;
    if ({r, b} !== {2'b00, 4'd5}) begin
      miscompares++;
      $display("FAIL single_write: got bresp=%b bid=%h, required 00/5", r, b);
    end
    do_read(9, 32'h10, 0, 2, 1, 0, ok);
    vectors++;
    if (!ok || {rd_data[0], rd_last[0], rd_resp[0]} !== {32'hDEADBEEF, 1'b1, 2'b00} ||
        rd_rid_bad != 0) begin
      miscompares++;
      $display("FAIL single_read: got rdata=%h rlast=%b rresp=%b rid_bad=%0d, required deadbeef/1/00/0",
               rd_data[0], rd_last[0], rd_resp[0], rd_rid_bad);
    end
  endtask

  task automatic test_incr4();
    logic [1:0] r, e;
    logic [3:0] b;
    bit ok;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    do_write(3, 32'h20, 3, 2, 1, -1, 3, r, b, ok);
    model_write(32'h20, 3, 2, 1, e);
    vectors++;
    if (r !== 2'b00) begin
      miscompares++;
      $display("FAIL incr4_bresp: got %b required 00", r);
    end
    for (int pass = 0; pass < 2; pass++) begin
      do_read(7, 32'h20, 3, 2, 1, pass[0], ok);
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (!ok || {rd_data[i], rd_last[i]} !== {32'(i + 1), (i == 3)}) begin
          miscompares++;
          $display("FAIL incr4_beat%0d pass%0d: got %h last=%b required %h last=%b",
                   i, pass, rd_data[i], rd_last[i], i + 1, i == 3);
        end
      end
      vectors++;
      if (pass == 0 ? (rd_cycles != 4 || rd_end_valid !== 1'b0) : (rd_unstable != 0)) begin
        miscompares++;
        $display("FAIL incr4_timing pass%0d: got cycles=%0d unstable=%0d endvalid=%b required 4/0/0",
                 pass, rd_cycles, rd_unstable, rd_end_valid);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] r, e;
    logic [3:0] b;
    bit ok;
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) begin d[i] = $urandom; wr_data[i] = d[i]; wr_strb[i] = 4'hF; end
    do_write(1, 32'h38, 3, 2, 2, -1, 1, r, b, ok);
    model_write(32'h38, 3, 2, 2, e);
    // Beats land on 0x38, 0x3C, 0x30, 0x34: linear 0x30.. holds d2,d3,d0,d1.
    do_read(2, 32'h30, 3, 2, 1, 0, ok);
    vectors++;
    if (r !== 2'b00 || !ok ||
        {rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {d[2], d[3], d[0], d[1]}) begin
      miscompares++;
      $display("FAIL wrap_write: got bresp=%b %h %h %h %h required 00 %h %h %h %h", r,
               rd_data[0], rd_data[1], rd_data[2], rd_data[3], d[2], d[3], d[0], d[1]);
    end
    do_read(2, 32'h38, 3, 2, 2, 1, ok);
    vectors++;
    if (!ok || {rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {d[0], d[1], d[2], d[3]}) begin
      miscompares++;
      $display("FAIL wrap_read: got %h %h %h %h required %h %h %h %h",
               rd_data[0], rd_data[1], rd_data[2], rd_data[3], d[0], d[1], d[2], d[3]);
    end
  endtask

  task automatic test_decerr();
    logic [1:0] r, e;
    logic [3:0] b;
    bit ok;
    wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
    do_write(4, 32'h400, 0, 2, 1, -1, 4, r, b, ok);
    model_write(32'h400, 0, 2, 1, e);
    vectors++;
    if (r !== 2'b11) begin
      miscompares++;
      $display("FAIL decerr_write: got bresp=%b required 11", r);
    end
    do_read(4, 32'h400, 0, 2, 1, 0, ok);
    vectors++;
    if (!ok || {rd_data[0], rd_resp[0]} !== {32'd0, 2'b11}) begin
      miscompares++;
      $display("FAIL decerr_read: got rdata=%h rresp=%b required 0/11", rd_data[0], rd_resp[0]);
    end
    // Burst straddling the top of memory: first beat lands, second is decoded out.
    wr_data[0] = 32'hCAFE0001; wr_data[1] = 32'hCAFE0002; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    do_write(6, 32'h3FC, 1, 2, 1, -1, 6, r, b, ok);
    model_write(32'h3FC, 1, 2, 1, e);
    do_read(6, 32'h3FC, 1, 2, 1, 0, ok);
    vectors++;
    if (r !== 2'b11 || !ok || {rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]} !==
        {32'hCAFE0001, 2'b00, 32'd0, 2'b11}) begin
      miscompares++;
      $display("FAIL decerr_edge: got bresp=%b %h/%b %h/%b required 11 cafe0001/00 0/11",
               r, rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r, e;
    logic [3:0] b;
    bit ok;
    wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'hF;
    do_write(0, 32'h80, 0, 2, 1, -1, 0, r, b, ok);
    model_write(32'h80, 0, 2, 1, e);
    wr_data[0] = 32'hAAAA5555; wr_strb[0] = 4'b0011;
    do_write(0, 32'h80, 0, 2, 1, -1, 0, r, b, ok);
    model_write(32'h80, 0, 2, 1, e);
    do_read(0, 32'h80, 0, 2, 1, 0, ok);
    vectors++;
    if (!ok || rd_data[0] !== 32'hFFFF5555) begin
      miscompares++;
      $display("FAIL strobe: got %h required ffff5555", rd_data[0]);
    end
  endtask

  task automatic test_wlast_err();
    logic [1:0] r, e;
    logic [3:0] b;
    bit ok;
    int lasts [2] = '{1, 16};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      do_write(8, 32'h100, 3, 2, 1, lasts[k], 8, r, b, ok);
      model_write(32'h100, 3, 2, 1, e);
      model_read(32'h100, 3, 2, 1);
      do_read(8, 32'h100, 3, 2, 1, 0, ok);
      vectors++;
      if (r !== 2'b10 || !ok || rd_data[0] !== exp_data[0] || rd_data[3] !== exp_data[3]) begin
        miscompares++;
        $display("FAIL wlast_err%0d: got bresp=%b d0=%h d3=%h required 10 %h %h",
                 k, r, rd_data[0], rd_data[3], exp_data[0], exp_data[3]);
      end
    end
  endtask

  task automatic test_wid();
    logic [1:0] r, e, want;
    logic [3:0] b;
    bit ok;
    wr_data[0] = 32'h0BADF00D; wr_data[1] = 32'h600DF00D; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    do_write(2, 32'h140, 1, 2, 1, -1, 13, r, b, ok);
    model_write(32'h140, 1, 2, 1, e);
`ifdef MODPORT_AXI_SLAVE_WID_CHECK_EN
    want = 2'b10;
`else
    want = 2'b00;
`endif
    model_read(32'h140, 1, 2, 1);
    do_read(2, 32'h140, 1, 2, 1, 0, ok);
    vectors++;
    if (r !== want || b !== 4'd2 || !ok || rd_data[1] !== exp_data[1]) begin
      miscompares++;
      $display("FAIL wid_mismatch: got bresp=%b bid=%h d1=%h required %b 2 %h",
               r, b, rd_data[1], want, exp_data[1]);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] r, e;
    logic [3:0] b;
    bit ok;
    int bursts [2] = '{3, 1};
    int sizes [2]  = '{2, 3};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
      do_write(k, 32'h200, 1, sizes[k], bursts[k], -1, k, r, b, ok);
      model_write(32'h200, 1, sizes[k], bursts[k], e);
      model_read(32'h200, 3, 2, 1);
      do_read(k, 32'h200, 3, 2, 1, 0, ok);
      vectors++;
      if (r !== 2'b10 || e !== 2'b10 || !ok || rd_data[0] !== exp_data[0] ||
          rd_data[1] !== exp_data[1] || rd_data[2] !== exp_data[2]) begin
        miscompares++;
        $display("FAIL illegal_write%0d: got bresp=%b d0=%h d1=%h required 10 %h %h",
                 k, r, rd_data[0], rd_data[1], exp_data[0], exp_data[1]);
      end
    end
    do_read(3, 32'h300, 2, 2, 2, 0, ok);
    vectors++;
    if (!ok || {rd_resp[0], rd_resp[1], rd_resp[2], rd_last[1], rd_last[2]} !== 8'b10101001) begin
      miscompares++;
      $display("FAIL wrap_len_bad: got resp=%b %b %b last=%b%b required 10 10 10 last=01",
               rd_resp[0], rd_resp[1], rd_resp[2], rd_last[1], rd_last[2]);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] r, e;
    logic [3:0] b;
    bit okw, okr;
    for (int i = 0; i < 8; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'hF; end
    model_read(32'h1C0, 7, 2, 1);
    fork
      do_write(10, 32'h180, 7, 2, 1, -1, 10, r, b, okw);
      do_read(11, 32'h1C0, 7, 2, 1, 1, okr);
    join
    model_write(32'h180, 7, 2, 1, e);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (!okr || rd_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL concurrent_read%0d: got %h required %h", i, rd_data[i], exp_data[i]);
      end
    end
    model_read(32'h180, 7, 2, 1);
    do_read(12, 32'h180, 7, 2, 1, 0, okr);
    vectors++;
    if (!okw || r !== 2'b00 || rd_data[7] !== exp_data[7] || rd_data[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL concurrent_write: got bresp=%b d0=%h d7=%h required 00 %h %h",
               r, rd_data[0], rd_data[7], exp_data[0], exp_data[7]);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    araddr = 32'h20; arlen = 4'd3; arsize = 3'd2; arburst = 2'b01; arid = 4'd1; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rvalid, arready, awready, rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_abort: got rvalid=%b arready=%b rdata=%h required 0/0/0",
               rvalid, arready, rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    model_read(32'h20, 3, 2, 1);
    do_read(1, 32'h20, 3, 2, 1, 0, ok);
    vectors++;
    if (!ok || rd_data[0] !== exp_data[0] || rd_data[3] !== exp_data[3]) begin
      miscompares++;
      $display("FAIL mem_kept: got %h %h required %h %h", rd_data[0], rd_data[3],
               exp_data[0], exp_data[3]);
    end
  endtask

  task automatic test_random();
    logic [1:0] r, e;
    logic [3:0] b;
    bit ok;
    int burst, size, len, step, start, id;
    int wlens [4] = '{1, 3, 7, 15};
    for (int n = 0; n < 40; n++) begin
      burst = $urandom_range(0, 2);
      size  = $urandom_range(0, 2);
      len   = (burst == 2) ? wlens[$urandom_range(0, 3)] : $urandom_range(0, 15);
      step  = 1 << size;
      start = $urandom_range(0, 32'h4FF) & ~(step - 1);
      id    = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
      do_write(id, start, len, size, burst, -1, id, r, b, ok);
      model_write(start, len, size, burst, e);
      vectors++;
      if (!ok || r !== e || b !== 4'(id)) begin
        miscompares++;
        $display("FAIL rand%0d_b: got bresp=%b bid=%h required %b %h (addr=%h len=%0d size=%0d burst=%0d)",
                 n, r, b, e, id[3:0], start, len, size, burst);
      end
      model_read(start, len, size, burst);
      do_read(id, start, len, size, burst, 1'($urandom_range(0, 1)), ok);
      for (int i = 0; i <= len; i++) begin
        vectors++;
        if (!ok || {rd_data[i], rd_resp[i], rd_last[i]} !== {exp_data[i], exp_resp[i], (i == len)}) begin
          miscompares++;
          $display("FAIL rand%0d_r%0d: got %h/%b/%b required %h/%b/%b (addr=%h burst=%0d)",
                   n, i, rd_data[i], rd_resp[i], rd_last[i], exp_data[i], exp_resp[i],
                   i == len, start, burst);
        end
      end
      vectors++;
      if (rd_unstable != 0 || rd_rid_bad != 0) begin
        miscompares++;
        $display("FAIL rand%0d_hold: got unstable=%0d rid_bad=%0d required 0/0",
                 n, rd_unstable, rd_rid_bad);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, completion required");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_single();
    test_incr4();
    test_wrap();
    test_decerr();
    test_strobe();
    test_wlast_err();
    test_wid();
    test_illegal();
    test_concurrent();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modport_axi_slave.md
# modport_axi_slave

AXI3-style memory slave that services the master side of the team's AXI interface (4-bit IDs, 32-bit address/data, 4-bit lengths, `wid` present). It is the responder behind the slave driver/monitor modports. It accepts one write burst and one read burst at a time, independently, and backs them with an on-chip word memory.

## Interface
- `MEM_WORDS`, default 256: memory depth in 32-bit words; must be a power of 2.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awvalid`, input 4/32/4/3/2/1: write address channel.
- `awready` output 1: write address ready.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid`, input 4/32/4/1/1: write data channel.
- `wready` output 1: write data ready.
- `bid`/`bresp`/`bvalid`, output 4/2/1: write response.
- `bready` input 1: write response accept.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`/`arvalid`, input 4/32/4/3/2/1: read address channel.
- `arready` output 1: read address ready.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid`, output 4/32/2/1/1: read data channel.
- `rready` input 1: read data accept.

## Operation
- Write FSM has states W_IDLE, W_DATA and W_RESP.
  - W_IDLE: `awready`=1. On `awvalid&&awready`, latch id, addr, len, size and burst, then go to W_DATA.
  - W_DATA: `wready`=1. Each `wvalid&&wready` beat writes the enabled bytes of `wdata` per `wstrb` to word `addr[log2(MEM_WORDS)+1:2]`.
  - After beat `len+1`, go to W_RESP. The burst always ends at beat `len+1`.
  - W_RESP: `bvalid`=1 and `bid`=latched awid. On `bready`, return to W_IDLE.
- Read FSM has states R_IDLE and R_DATA.
  - R_IDLE: `arready`=1. On handshake, latch the request, load beat 0 data, and go to R_DATA.
  - R_DATA: `rvalid`=1, `rid`=latched arid, `rlast`=1 on beat `len+1`. Each `rready` advances to the next beat. After the last beat, return to R_IDLE.
- Address sequencing uses step = 2^size.
  - FIXED (00): address held.
  - INCR (01): address += step.
  - WRAP (10): wrap boundary = (len+1)·step, aligned down.
- Error responses are OKAY=00, SLVERR=10, DECERR=11. Both response codes are per burst.
  - SLVERR: `burst`=11; `size`>2; WRAP with len not in {1,3,7,15}; `wlast` asserted on any beat other than the last, or deasserted on the last beat.
  - On SLVERR writes still commit, except when burst or size is illegal; then no writes occur.
  - DECERR: any beat address ≥ MEM_WORDS·4. That beat's write is dropped and its read data is 0.
  - DECERR takes precedence over SLVERR.
- Read responses report `rresp` per beat using the same rules.

## Timing
- All outputs are registered. During and at reset, every output is 0.
- `awready` and `arready` go to 1 on the first edge after `rst` falls.
- Ready drops in the cycle after the address handshake.
- `wready` rises the cycle after the AW handshake.
- `bvalid` rises the cycle after the last W beat and holds until `bready`.
- `rvalid` with beat 0 rises the cycle after the AR handshake. Back-to-back beats are delivered every cycle while `rready`=1.
- `rdata`, `rresp` and `rlast` stay stable while `rvalid && !rready`.
- A write and a read to the same word on the same edge: the read returns the pre-write data.
- Read and write FSMs run concurrently. There is no read/write ordering guarantee.
- `rst` mid-burst aborts both FSMs. Memory contents are not cleared.

## Configuration
- `MODPORT_AXI_SLAVE_WID_CHECK_EN` defined: any beat with `wid` ≠ latched awid makes `bresp`=SLVERR. The write still commits.
- Macro undefined: `wid` is ignored.

## Structure
- The package `modport_axi_pkg` holds:
  - `burst_e` (FIXED/INCR/WRAP);
  - `resp_e` (OKAY/SLVERR/DECERR);
  - the write and read FSM state enums;
  - the next-address function (addr, size, len, burst).
- There is one sub-module, `modport_axi_mem`: a byte-enabled single-write/single-read word RAM.

## Test plan
- Reset, then 1-beat INCR write of 0xDEADBEEF, `wstrb`=F, to 0x10 → `bresp`=00 and `bid`=awid; read of 0x10 → `rdata`=0xDEADBEEF, `rlast`=1, `rresp`=00.
- 4-beat INCR write to 0x20 with data 1..4, then read of the same burst → rdata 1,2,3,4 with `rlast` only on beat 4. Repeat with `rready` toggling → data holds while stalled.
- WRAP with len=3 and size=2 at 0x38 → words 0x38, 0x3C, 0x30, 0x34.
- Write to 0x400 (MEM_WORDS=256) → `bresp`=11. Read of 0x400 → `rdata`=0, `rresp`=11.
- `wstrb`=0011 with 0xAAAA5555 over 0xFFFFFFFF → readback 0xFFFF5555.
- `wlast` asserted on beat 2 of a 4-beat burst → `bresp`=10 and all 4 beats are accepted. With the macro defined, a `wid` mismatch → `bresp`=10.
